// File: rtl/ofm_pad_writer.sv
// rtl/ofm_pad_writer.sv - padded raster write controller for the layer-2 IFM buffer
module ofm_pad_writer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic [1:0]        pad,
  input  logic              ofm_valid,
  input  logic [127:0]      ofm_data,
  output logic              ofm_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // address of the next write
  logic [8:0]          pw_q, pw_d;           // padded plane width
  logic [8:0]          lo_q, lo_d;           // first interior row/column
  logic [8:0]          hi_q, hi_d;           // first border row/column past the interior
  logic [3:0]          tiles_q, tiles_d;
  logic [8:0]          t_q, t_d, r_q, r_d, c_q, c_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [127:0]        wr_data_q, wr_data_d;
  logic                done_q, done_d;

  logic                border;
  logic                last_col, last_row, last_tile;
  logic                unused_low_ch;

  // The channel count only matters in whole 16-channel tiles.
  assign unused_low_ch = ^OFM_C[3:0];

  assign border    = (r_q < lo_q) || (r_q >= hi_q) || (c_q < lo_q) || (c_q >= hi_q);
  assign last_col  = (c_q == pw_q - 9'd1);
  assign last_row  = (r_q == pw_q - 9'd1);
  assign last_tile = ((t_q + 9'd1) == {5'b0, tiles_q});

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  // busy covers the done-pulse cycle so a new start cannot overlap it.
  assign busy    = (state_q != S_IDLE) || done_q;

  // Next-state, walk advance and write decision.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pw_d      = pw_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    tiles_d   = tiles_q;
    t_d       = t_q;
    r_d       = r_q;
    c_d       = c_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ofm_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          addr_d  = base_addr;
          pw_d    = {1'b0, OFM_W} + {6'b0, pad, 1'b0};
          lo_d    = {7'b0, pad};
          hi_d    = {1'b0, OFM_W} + {7'b0, pad};
          tiles_d = OFM_C[7:4];
          t_d     = 9'd0;
          r_d     = 9'd0;
          c_d     = 9'd0;
          state_d = (OFM_C[7:4] == 4'd0 || OFM_W == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        ofm_ready = !border;
        if (border || ofm_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = border ? 128'd0 : ofm_data;
          addr_d    = addr_q + ADDR_W'(1);
          if (!last_col) begin
            c_d = c_q + 9'd1;
          end else begin
            c_d = 9'd0;
            if (!last_row) begin
              r_d = r_q + 9'd1;
            end else begin
              r_d = 9'd0;
              t_d = t_q + 9'd1;
              if (last_tile) begin
                t_d     = 9'd0;
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, configuration, counters and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      pw_q      <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      tiles_q   <= '0;
      t_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pw_q      <= pw_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      tiles_q   <= tiles_d;
      t_q       <= t_d;
      r_q       <= r_d;
      c_q       <= c_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/ofm_pad_writer.md
# ofm_pad_writer

Write-side controller for the 128-bit layer-2 IFM buffer. It accepts the 16-channel (16×8-bit) OFM vectors from the layer-1 PE cluster and streams them into the layer-2 BRAM in padded raster order. It autonomously inserts zero words for the border ring of width `pad` around each OFM tile plane. It generates the BRAM write enable, address and data, so layer 2 reads a ready-padded IFM with no extra pass.

## Interface
Parameters:
- `ADDR_W`, 32: write address width.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches the configuration and begins a layer. Ignored while `busy`=1.
- `base_addr` in ADDR_W: first write address, latched on `start`.
- `OFM_W` in 8: unpadded OFM width; the plane is square, so OFM height = `OFM_W`.
- `OFM_C` in 8: OFM channels. Tiles = `OFM_C` >> 4; low 4 bits are ignored.
- `pad` in 2: zero-border width, 0..3.
- `ofm_valid` in 1: `ofm_data` holds the next interior pixel.
- `ofm_data` in 128: {ch15..ch0}, 8 bits each; ch0 is in [7:0].
- `ofm_ready` out 1: interior beat accepted when `ofm_valid` && `ofm_ready`.
- `wr_en` out 1: BRAM write strobe.
- `wr_addr` out ADDR_W: BRAM write address.
- `wr_data` out 128: BRAM write data.
- `busy` out 1: a layer is in progress.
- `done` out 1: one-cycle pulse when the layer is complete.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Latch `base_addr`, PW = `OFM_W` + 2·`pad` (9-bit), T = `OFM_C`>>4.
  - Clear the counters t, r, c (all 9-bit).
  - If T==0 or `OFM_W`==0, go to DONE; otherwise go to RUN.
- RUN walks the padded planes with tile outermost, then row r in 0..PW-1, then column c in 0..PW-1.
- Border cell: r<pad, r≥pad+`OFM_W`, c<pad, or c≥pad+`OFM_W`.
  - `ofm_ready`=0.
  - The controller issues a write of all-zero data unconditionally and advances the walk.
- Interior cell: `ofm_ready`=1.
  - On `ofm_valid`, write `ofm_data` and advance; otherwise stall with no write.
- Write address = latched base + running write count. The layout is contiguous: tile t occupies base + t·PW² .. base + (t+1)·PW² − 1. Addresses wrap modulo 2^ADDR_W.
- The walk advances c, then r, then t. At the final cell (t=T-1, r=c=PW-1) the FSM goes to DONE once that cell's write is issued.
- DONE: assert `done` for one cycle, then go to IDLE.
- `busy`=1 in RUN and DONE.
- `ofm_valid` while `ofm_ready`=0 is not consumed. The upstream source holds the data.
- `pad`=0: every cell is interior and there are no zero writes.
- Total writes per layer = T·PW².

## Timing
- Reset values: `ofm_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0. The FSM is in IDLE and all counters are 0.
- `wr_en`, `wr_addr` and `wr_data` are registered. A write decided in cycle k (border cell, or accepted beat) is visible in cycle k+1.
- `ofm_ready` is combinational from state and counters; it has no dependence on `ofm_valid`.
- `start` high in cycle N:
  - `busy`=1 from cycle N+1.
  - The first write decision is in cycle N+1; the first `wr_en` is high in cycle N+2.
- Throughput is one write per cycle. The border never stalls; interior cells stall only on `ofm_valid`=0.
- Last `wr_en` in cycle M: `done`=1 in cycle M+1. `busy` falls in cycle M+2, and a new `start` is accepted from cycle M+2.
- Degenerate start (T==0 or `OFM_W`==0) in cycle N: `done` is high in cycle N+2 with no writes.
- `start` during RUN or DONE has no effect.
- Reset asserted mid-layer: all outputs go to their reset values immediately (asynchronously). Partial writes are abandoned and no `done` is issued.

## Test plan
- `OFM_W`=2, `OFM_C`=16, `pad`=1, base=0x100, `ofm_valid` held high with data D0..D3:
  - 16 writes at 0x100..0x10F in cycles N+2..N+17.
  - D0..D3 land at 0x105, 0x106, 0x109, 0x10A; all other writes are zero.
  - `done` is high in cycle N+18.
- Same configuration with `ofm_valid` low for 3 cycles before D2: `ofm_ready` holds at cell (2,1) and `wr_en` drops for exactly 3 cycles. Addresses and data are otherwise identical and `done` is 3 cycles later.
- `OFM_W`=3, `OFM_C`=32, `pad`=0: 18 writes, all from `ofm_data`. Tile 1 starts at base+9, and no `ofm_ready`=0 cycle occurs during RUN.
- `OFM_C`=8: no writes; `done` is high in cycle N+2.
- `OFM_W`=2, `pad`=3, base=0xFFFFFFF0: PW=8 and 64 writes. Addresses wrap to 0x00000000 after 0xFFFFFFFF.
- Reset pulse after 5 writes, then `start` again: all outputs are 0 during reset. The new layer restarts at the new base with the counters cleared.
